// File: rtl/prog_timer_bank.sv
// N-channel programmable timer: square, one-shot and rate modes per channel,
// configured through one addressed write port ({channel, sel} addressing).
module prog_timer_bank #(
  parameter  int NUM_CH = 2,
  parameter  int CNT_W  = 8,
  localparam int AW     = $clog2(NUM_CH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     addr,
  input  logic [CNT_W-1:0]  wdata,
  input  logic [NUM_CH-1:0] gate,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] tc
);

  localparam logic [1:0] MODE_SQ   = 2'd0;
  localparam logic [1:0] MODE_OS   = 2'd1;
  localparam logic [1:0] MODE_RATE = 2'd2;
  localparam logic [1:0] MODE_OFF  = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [AW-1:0]    w_ch_idx;
  logic             w_sel;
  logic [CNT_W-1:0] w_wdata_cl;

  assign w_ch_idx   = addr >> 1;
  assign w_sel      = addr[0];
  // A divisor below 2 cannot form a period, so 0 and 1 are treated as 2.
  assign w_wdata_cl = (wdata < CNT_W'(2)) ? CNT_W'(2) : wdata;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_pend;
    logic [CNT_W-1:0] r_p;
    logic [0:0]       r_state;
    logic             r_gate_q;
    logic             r_out;
    logic             r_tc;

    logic             w_hit;
    logic             w_wr_div;
    logic             w_wr_mode;
    logic             w_last;
    logic             w_trig;
    logic [1:0]       w_mode_next;
    logic [CNT_W-1:0] w_pend_next;
    logic [CNT_W-1:0] w_act_next;
    logic [CNT_W-1:0] w_p_next;
    logic [0:0]       w_state_next;
    logic             w_tc_next;
    logic             w_out_next;
    logic [CNT_W:0]   w_half;

    assign w_hit       = wr_en && (w_ch_idx == AW'(gi));
    assign w_wr_div    = w_hit && !w_sel;
    assign w_wr_mode   = w_hit && w_sel;
    assign w_pend_next = w_wr_div ? w_wdata_cl : r_div_pend;
    assign w_last      = (r_p == r_div_act - CNT_W'(1));
    assign w_trig      = gate[gi] && !r_gate_q;
    // Extra bit keeps (N+1)>>1 exact when N is all ones.
    assign w_half      = ({1'b0, w_act_next} + {{CNT_W{1'b0}}, 1'b1}) >> 1;

    always_comb begin
      w_mode_next  = r_mode;
      w_act_next   = r_div_act;
      w_p_next     = r_p;
      w_state_next = r_state;
      w_tc_next    = r_tc;
      if (w_wr_mode) begin
        w_mode_next  = wdata[1:0];
        w_p_next     = '0;
        w_tc_next    = 1'b0;
        w_state_next = ST_IDLE;
        w_act_next   = w_pend_next;
      end else begin
        case (r_mode)
          MODE_SQ, MODE_RATE: begin
            if (gate[gi]) begin
              if (w_last) begin
                w_p_next   = '0;
                w_tc_next  = 1'b1;
                w_act_next = w_pend_next;
              end else begin
                w_p_next  = r_p + CNT_W'(1);
                w_tc_next = 1'b0;
              end
            end
          end
          MODE_OS: begin
            if (r_state == ST_IDLE) begin
              w_p_next   = '0;
              w_tc_next  = 1'b0;
              w_act_next = w_pend_next;
              if (w_trig) w_state_next = ST_RUN;
            end else if (w_trig) begin
              w_p_next  = '0;
              w_tc_next = 1'b0;
            end else if (w_last) begin
              w_p_next     = '0;
              w_tc_next    = 1'b1;
              w_state_next = ST_IDLE;
              w_act_next   = w_pend_next;
            end else begin
              w_p_next  = r_p + CNT_W'(1);
              w_tc_next = 1'b0;
            end
          end
          default: begin
            w_p_next   = '0;
            w_tc_next  = 1'b0;
            w_act_next = w_pend_next;
          end
        endcase
      end

      // Output derives from the post-edge phase so out and p move together.
      case (w_mode_next)
        MODE_SQ:   w_out_next = ({1'b0, w_p_next} < w_half);
        MODE_RATE: w_out_next = (w_p_next == w_act_next - CNT_W'(1));
        MODE_OS:   w_out_next = (w_state_next == ST_RUN);
        default:   w_out_next = 1'b0;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_mode     <= MODE_OFF;
        r_div_act  <= CNT_W'(2);
        r_div_pend <= CNT_W'(2);
        r_p        <= '0;
        r_state    <= ST_IDLE;
        r_gate_q   <= 1'b0;
        r_out      <= 1'b0;
        r_tc       <= 1'b0;
      end else begin
        r_mode     <= w_mode_next;
        r_div_act  <= w_act_next;
        r_div_pend <= w_pend_next;
        r_p        <= w_p_next;
        r_state    <= w_state_next;
        r_gate_q   <= gate[gi];
        r_out      <= w_out_next;
        r_tc       <= w_tc_next;
      end
    end

    assign out[gi] = r_out;
    assign tc[gi]  = r_tc;
  end

endmodule

// File: tb/tb_prog_timer_bank.sv
// Scoreboard bench for prog_timer_bank (3 channels, 4-bit counters): the driver
// queues hand-computed out/tc per edge, the monitor pops and compares.
module tb_prog_timer_bank;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 4;
  localparam int AW     = 3;

  logic              clk   = 1'b0;
  logic              rst   = 1'b1;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     addr  = '0;
  logic [CNT_W-1:0]  wdata = '0;
  logic [NUM_CH-1:0] gate  = '0;
  logic [NUM_CH-1:0] out;
  logic [NUM_CH-1:0] tc;

  typedef struct {
    logic [2:0] eo;
    logic [2:0] et;
    logic [2:0] m;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  prog_timer_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .addr  (addr),
    .wdata (wdata),
    .gate  (gate),
    .out   (out),
    .tc    (tc)
  );

  always #5 clk = ~clk;

  // Monitor: every clock edge or reset assertion presents a new output word.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.m != 3'b000) begin
          n_vec++;
          if (((out & e.m) !== (e.eo & e.m)) || ((tc & e.m) !== (e.et & e.m))) begin
            n_bad++;
            $display("FAIL %s: out=%b tc=%b, want out=%b tc=%b (mask %b) t=%0t",
                     e.nm, out, tc, e.eo, e.et, e.m, $time);
          end else begin
            $display("ok   %s: out=%b tc=%b (mask %b)", e.nm, out, tc, e.m);
          end
        end
      end
    end
  end

  task automatic vec(input logic [2:0] g, input logic we, input logic [2:0] a,
                     input logic [3:0] d, input logic [2:0] eo, input logic [2:0] et,
                     input logic [2:0] m, input string nm);
    exp_t e;
    @(negedge clk);
    gate  = g;
    wr_en = we;
    addr  = a;
    wdata = d;
    e.eo = eo;
    e.et = et;
    e.m  = m;
    e.nm = nm;
    sb.push_back(e);
  endtask

  logic [31:0] sg, so, st, so0, st0;

  initial begin
    exp_t e;
    vec(3'b000, 1'b0, 3'b000, 4'd0, 3'b000, 3'b000, 3'b111, "reset_state");
    @(negedge clk);
    rst = 1'b0;

    // ch0 square, divisor 4
    vec(3'b000, 1'b1, 3'b000, 4'd4, 3'b000, 3'b000, 3'b001, "ch0_div4");
    vec(3'b000, 1'b1, 3'b001, 4'd0, 3'b001, 3'b000, 3'b001, "ch0_mode_sq");
    so = 32'b10011001;
    st = 32'b00010001;
    for (int i = 0; i < 8; i++)
      vec(3'b001, 1'b0, 3'b000, 4'd0, {2'b00, so[7-i]}, {2'b00, st[7-i]}, 3'b001, "ch0_sq4");

    // ch1 square, divisor 5, gated pause; ch0 keeps running
    vec(3'b001, 1'b1, 3'b010, 4'd5, 3'b001, 3'b000, 3'b011, "ch1_div5");
    vec(3'b001, 1'b1, 3'b011, 4'd0, 3'b010, 3'b000, 3'b011, "ch1_mode_sq");
    sg  = 32'b111111000111111;
    so  = 32'b110011111100111;
    st  = 32'b000010000000100;
    so0 = 32'b011001100110011;
    st0 = 32'b010001000100010;
    for (int i = 0; i < 15; i++)
      vec({1'b0, sg[14-i], 1'b1}, 1'b0, 3'b000, 4'd0, {1'b0, so[14-i], so0[14-i]},
          {1'b0, st[14-i], st0[14-i]}, 3'b011, "ch1_gated");

    // ch0 one-shot, divisor 3, then retrigger
    vec(3'b000, 1'b1, 3'b001, 4'd1, 3'b000, 3'b000, 3'b001, "ch0_mode_os");
    vec(3'b000, 1'b1, 3'b000, 4'd3, 3'b000, 3'b000, 3'b001, "ch0_div3");
    sg = 32'b1111101011111;
    so = 32'b1110001111100;
    st = 32'b0001000000010;
    for (int i = 0; i < 13; i++)
      vec({2'b00, sg[12-i]}, 1'b0, 3'b000, 4'd0, {2'b00, so[12-i]}, {2'b00, st[12-i]}, 3'b001, "ch0_oneshot");

    // ch0 rate, divisor 6 -> 3 mid-period -> 0 (clamped to 2)
    vec(3'b000, 1'b1, 3'b000, 4'd6, 3'b000, 3'b000, 3'b001, "ch0_div6");
    vec(3'b000, 1'b1, 3'b001, 4'd2, 3'b000, 3'b000, 3'b001, "ch0_mode_rate");
    so = 32'b0000100100101010;
    st = 32'b0000010010010101;
    for (int i = 0; i < 16; i++)
      vec(3'b001, (i == 2 || i == 9), 3'b000, (i == 2) ? 4'd3 : 4'd0,
          {2'b00, so[15-i]}, {2'b00, st[15-i]}, 3'b001, "ch0_rate");

    // ch1 resumes to a wrap, then asynchronous reset mid-count
    so = 32'b001;
    st = 32'b001;
    for (int i = 0; i < 3; i++)
      vec(3'b011, 1'b0, 3'b000, 4'd0, {1'b0, so[2-i], 1'b0}, {1'b0, st[2-i], 1'b0}, 3'b010, "ch1_pre_rst");
    @(negedge clk);
    e.eo = 3'b000;
    e.et = 3'b000;
    e.m  = 3'b111;
    e.nm = "async_rst";
    sb.push_back(e);
    #1 rst = 1'b1;
    vec(3'b011, 1'b0, 3'b000, 4'd0, 3'b000, 3'b000, 3'b111, "rst_held");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++)
      vec(3'b111, 1'b0, 3'b000, 4'd0, 3'b000, 3'b000, 3'b111, "post_rst_off");

    // ch2 divisor 15, invalid channel-3 writes ignored
    vec(3'b000, 1'b1, 3'b100, 4'd15, 3'b000, 3'b000, 3'b111, "ch2_div15");
    vec(3'b000, 1'b1, 3'b111, 4'd0, 3'b000, 3'b000, 3'b111, "bad_addr_mode");
    vec(3'b000, 1'b1, 3'b110, 4'd3, 3'b000, 3'b000, 3'b111, "bad_addr_div");
    vec(3'b000, 1'b1, 3'b101, 4'd0, 3'b100, 3'b000, 3'b111, "ch2_mode_sq");
    so = 32'b1111111000000011;
    st = 32'b0000000000000010;
    for (int i = 0; i < 16; i++)
      vec(3'b100, 1'b0, 3'b000, 4'd0, {so[15-i], 2'b00}, {st[15-i], 2'b00}, 3'b111, "ch2_sq15");

    repeat (10) @(posedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_timer_bank.md
Name: prog_timer_bank

Overview:
- Parametrised N-channel programmable timer, the successor to the fixed 2-channel gated clock divider.
- Each channel has a gate input, a programmable divisor and four modes: disabled, square wave, one-shot and rate generator.
- Channels are configured through a single addressed write port and sit beside the existing timer as a drop-in, wider and multi-mode replacement.

Parameters:
- NUM_CH, 2, number of independent timer channels (1..16).
- CNT_W, 8, divisor and phase-counter width in bits (2..16).
- AW, $clog2(NUM_CH)+1 (derived, localparam), address width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe, sampled on posedge clk.
- addr  in  AW  {channel index, sel}; sel=0 selects the divisor, sel=1 selects the mode.
- wdata  in  CNT_W  write data. Divisor uses all bits; mode uses wdata[1:0].
- gate  in  NUM_CH  per-channel gate, synchronous to clk.
- out  out  NUM_CH  per-channel timer output, registered.
- tc  out  NUM_CH  per-channel terminal-count pulse, one cycle, registered.

Behaviour:
- Reset (async, immediate):
  - all out=0, tc=0, phase p=0;
  - mode=3 (disabled); active and pending divisor=2;
  - one-shot state=IDLE; gate_q=0.
- Divisor write:
  - Values 0 and 1 clamp to 2.
  - The value goes to the pending register.
  - pending->active transfer happens at the next wrap (p==N-1 while advancing), or immediately if the channel is in mode 3 or one-shot IDLE.
  - If a write coincides with a wrap, the new value is used from the wrap.
- Mode write (0=square, 1=one-shot, 2=rate, 3=disabled):
  - Takes effect at that edge: p<=0, tc<=0, one-shot state<=IDLE, pending divisor copied to active.
  - out<=f(mode,0) per the rules below (mode 1 gives 0).
- Invalid addresses: writes with channel index >= NUM_CH are ignored.
- out and tc are computed from next-state p, so both update on the same edge as p.
- Mode 0, square (N = active divisor):
  - When gate=1, p advances 0..N-1 and wraps.
  - out=1 when p < ceil(N/2), else 0; odd N gives the extra cycle high.
  - When gate=0, p, out and tc hold.
  - tc=1 for the cycle after the edge on which p wraps N-1->0.
- Mode 2, rate:
  - Same counting as mode 0.
  - out=1 only while p==N-1, i.e. a one-cycle pulse every N gated cycles; tc as in mode 0.
- Mode 1, one-shot (states IDLE/RUN):
  - gate_q registers gate every cycle; the trigger is gate=1 and gate_q=0.
  - IDLE + trigger: p<=0, out<=1, state RUN.
  - RUN: p advances every cycle regardless of gate level. At p==N-1: out<=0, tc<=1, state IDLE, pending loaded. Net result: out high for exactly N cycles.
  - RUN + trigger (retrigger): p<=0, out stays 1, so the pulse extends.
  - IDLE without trigger: out=0.
- Mode 3, disabled: p=0, out=0, tc=0, gate ignored.
- Arithmetic: p is CNT_W bits. ceil(N/2) is computed as (N+1)>>1 in CNT_W+1 bits, with no overflow at N=2^CNT_W-1.
- Channel independence: channels share only the write port; a write to one channel never alters another.
- Reset asserted mid-count returns everything to reset values; the first edge after deassertion behaves as in the reset state.

Test Plan:
- After reset: out=0, tc=0. Write ch0 divisor=4, then ch0 mode=0; hold gate[0]=1 -> out[0] repeats 1,1,0,0; tc[0] pulses every 4 cycles.
- ch1 divisor=5, mode=0, gate[1]=1 for 6 cycles, 0 for 3, then 1 -> out[1] 1,1,1,0,0 pattern, frozen for 3 cycles mid-period; ch0 unaffected.
- ch0 mode=1, divisor=3; pulse gate[0] 0->1 -> out[0] high exactly 3 cycles, tc[0] on its falling edge. Retrigger at cycle 2 -> out high for 5 total cycles.
- ch0 mode=2, divisor=6 running; write divisor=3 mid-period -> current period completes at 6 cycles, following periods are 3. Write divisor=0 -> behaves as 2.
- Assert rst while ch1 is mid-count in mode 0 -> out/tc=0 immediately (async); after release, mode=3 and out stays 0 with gate high.
- NUM_CH=3, CNT_W=4: write to channel index 3 is ignored. Divisor 15 in mode 0 -> out high 8 cycles, low 7.
